led_rate_decoder: RTL and testbench

LED_RATE_DECODER -- requirements
Module: led_rate_decoder

---
 rtl/led_rate_pkg.sv | 55 +++++
 rtl/led_sync_edge.sv | 57 +++++
 rtl/led_rate_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_led_rate_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/led_rate_pkg.sv
// -----------------------------------------------------------------------------
// led_rate_pkg
//   Shared types, constants and helpers for the LED rate decoder.
//   - state_t      : decoder FSM states
//   - RATE_*       : step-rate codes as driven on the sw output
//   - rate_period  : nominal step period in clock cycles for a rate code
//   - in_window    : symmetric tolerance-window test used by the classifier
// -----------------------------------------------------------------------------
package led_rate_pkg;

  // Width of the observed counter bus.
  localparam int LED_W = 8;

  // Width of the saturating interval counter.
  localparam int CNT_W = 30;

  // Deltas (modulo 256) that count as a legal single step.
  localparam logic [LED_W-1:0] STEP_UP   = 8'h01;
  localparam logic [LED_W-1:0] STEP_DOWN = 8'hFF;

  // Rate codes, fastest first.
  localparam logic [1:0] RATE_100HZ = 2'd3;
  localparam logic [1:0] RATE_10HZ  = 2'd2;
  localparam logic [1:0] RATE_1HZ   = 2'd1;
  localparam logic [1:0] RATE_0HZ1  = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // no usable history; waiting for a legal step
    ST_MEASURE   = 2'd1,  // one reference strobe seen; next interval is measured
    ST_CANDIDATE = 2'd2,  // one classified interval seen; needs one confirmation
    ST_LOCKED    = 2'd3   // rate and direction confirmed; outputs trustworthy
  } state_t;

  // Nominal step period in clock cycles for the given rate code.
  function automatic logic [31:0] rate_period(input int unsigned clk_hz,
                                              input logic [1:0]  code);
    logic [31:0] p;
    case (code)
      RATE_100HZ: p = clk_hz / 32'd100;
      RATE_10HZ:  p = clk_hz / 32'd10;
      RATE_1HZ:   p = clk_hz;
      default:    p = clk_hz * 32'd10;
    endcase
    return p;
  endfunction

  // True when |n - p| <= tol, written without a signed subtraction so no
  // intermediate value can underflow.
  function automatic logic in_window(input logic [31:0] n,
                                     input logic [31:0] p,
                                     input logic [31:0] tol);
    return ((n + tol) >= p) && (n <= (p + tol));
  endfunction

endpackage

// File: rtl/led_sync_edge.sv
// -----------------------------------------------------------------------------
// led_sync_edge
//   Brings the asynchronous LED counter bus into the clk domain and detects
//   changes of its value.
//
//   Ports
//     clk     in   system clock, rising edge
//     reset   in   asynchronous active-high reset
//     led     in   observed counter value (asynchronous to clk)
//     cur     out  current synchronized value (updated with the strobe)
//     prev    out  value held before the most recent change
//     strobe  out  one-cycle pulse, three cycles after led changes; cur/prev
//                  describe that change while the strobe is high
// -----------------------------------------------------------------------------
module led_sync_edge
  import led_rate_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] led,
  output logic [LED_W-1:0] cur,
  output logic [LED_W-1:0] prev,
  output logic             strobe
);

  logic [LED_W-1:0] meta;
  logic [LED_W-1:0] sync;
  logic             changed;

  // A bus caught mid-transition can settle on a value that was never driven
  // for one cycle; the decoder then sees an illegal step and resynchronizes.
  assign changed = (sync != cur);

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking assignments would collapse
  // the synchronizer chain into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= '0;
      sync   <= '0;
      cur    <= '0;
      prev   <= '0;
      strobe <= 1'b0;
    end else begin
      meta   <= led;
      sync   <= meta;
      cur    <= sync;
      strobe <= changed;
      // prev only moves on a change so it always holds the value the counter
      // stepped away from.
      if (changed) begin
        prev <= cur;
      end
    end
  end

endmodule

// File: rtl/led_rate_decoder.sv
// -----------------------------------------------------------------------------
// led_rate_decoder
//   Watches an 8-bit counter driven from another clock domain and recovers
//   its step rate and count direction from the spacing and sign of its steps.
//
//   Parameters
//     CLK_HZ     system clock frequency in Hz
//     TOL_SHIFT  interval tolerance is nominal period >> TOL_SHIFT
//
//   Ports
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-high reset
//     led    in   observed counter value (asynchronous to clk)
//     sw     out  decoded rate: 3=100 Hz, 2=10 Hz, 1=1 Hz, 0=0.1 Hz
//     ud     out  decoded direction: 1=up, 0=down
//     valid  out  sw/ud locked and trustworthy
//     err    out  one-cycle pulse on an illegal step or unclassifiable interval
// -----------------------------------------------------------------------------
module led_rate_decoder
  import led_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TOL_SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] led,
  output logic [1:0]       sw,
  output logic             ud,
  output logic             valid,
  output logic             err
);

  // Nominal periods and tolerance windows, all in clock cycles.
  localparam logic [31:0] PERIOD_3 = rate_period(CLK_HZ, RATE_100HZ);
  localparam logic [31:0] PERIOD_2 = rate_period(CLK_HZ, RATE_10HZ);
  localparam logic [31:0] PERIOD_1 = rate_period(CLK_HZ, RATE_1HZ);
  localparam logic [31:0] PERIOD_0 = rate_period(CLK_HZ, RATE_0HZ1);
  localparam logic [31:0] TOL_3    = PERIOD_3 >> TOL_SHIFT;
  localparam logic [31:0] TOL_2    = PERIOD_2 >> TOL_SHIFT;
  localparam logic [31:0] TOL_1    = PERIOD_1 >> TOL_SHIFT;
  localparam logic [31:0] TOL_0    = PERIOD_0 >> TOL_SHIFT;

  // Longest interval that could still belong to the slowest rate.
  localparam logic [31:0] TIMEOUT_LIMIT = PERIOD_0 + TOL_0;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchronizer and change detection
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] cur;
  logic [LED_W-1:0] prev;
  logic             strobe;

  led_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .led    (led),
    .cur    (cur),
    .prev   (prev),
    .strobe (strobe)
  );

  // ---------------------------------------------------------------------------
  // Step decode: delta is taken modulo 256, so 0xFF->0x00 is +1 and
  // 0x00->0xFF is -1 without any special casing.
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] delta;
  logic             step_up;
  logic             step_legal;

  assign delta      = cur - prev;
  assign step_up    = (delta == STEP_UP);
  assign step_legal = step_up || (delta == STEP_DOWN);

  // ---------------------------------------------------------------------------
  // Interval measurement
  //   The counter clears on the strobe edge and counts every other edge, so
  //   while the next strobe is high it holds (interval - 1). interval is the
  //   elapsed cycle count since the previous strobe.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] counter;
  logic [31:0]      interval;
  logic             timed_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else if (strobe) begin
      counter <= '0;
    end else if (counter != '1) begin
      counter <= counter + CNT_ONE;
    end
  end

  assign interval  = 32'(counter) + 32'd1;
  assign timed_out = (interval > TIMEOUT_LIMIT);

  // ---------------------------------------------------------------------------
  // Interval classifier, fastest rate first.
  // ---------------------------------------------------------------------------
  logic       class_hit;
  logic [1:0] class_code;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    class_hit  = 1'b1;
    class_code = RATE_0HZ1;
    if (in_window(interval, PERIOD_3, TOL_3)) begin
      class_code = RATE_100HZ;
    end else if (in_window(interval, PERIOD_2, TOL_2)) begin
      class_code = RATE_10HZ;
    end else if (in_window(interval, PERIOD_1, TOL_1)) begin
      class_code = RATE_1HZ;
    end else if (in_window(interval, PERIOD_0, TOL_0)) begin
      class_code = RATE_0HZ1;
    end else begin
      class_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [1:0] cand_code;
  logic [1:0] cand_code_next;
  logic       cand_dir;
  logic       cand_dir_next;
  logic [1:0] sw_next;
  logic       ud_next;
  logic       valid_next;
  logic       err_next;
  logic       good_step;

  // A step that can feed the lock logic: legal delta and a recognizable rate.
  assign good_step = step_legal && class_hit;

  always_comb begin
    state_next     = state;
    cand_code_next = cand_code;
    cand_dir_next  = cand_dir;
    sw_next        = sw;
    ud_next        = ud;
    valid_next     = valid;
    err_next       = 1'b0;

    if (strobe) begin
      // A strobe always wins over a simultaneous timeout.
      if (state == ST_IDLE) begin
        // No previous strobe to measure against, so only the delta matters.
        if (step_legal) begin
          state_next = ST_MEASURE;
        end else begin
          err_next = 1'b1;
        end
      end else if (!good_step) begin
        err_next   = 1'b1;
        valid_next = 1'b0;
        state_next = ST_MEASURE;
      end else begin
        case (state)
          ST_MEASURE: begin
            state_next     = ST_CANDIDATE;
            cand_code_next = class_code;
            cand_dir_next  = step_up;
          end
          ST_CANDIDATE: begin
            if ((class_code == cand_code) && (step_up == cand_dir)) begin
              state_next = ST_LOCKED;
              sw_next    = cand_code;
              ud_next    = cand_dir;
              valid_next = 1'b1;
            end else begin
              // Not a confirmation: this step becomes the new candidate.
              cand_code_next = class_code;
              cand_dir_next  = step_up;
            end
          end
          ST_LOCKED: begin
            if ((class_code != sw) || (step_up != ud)) begin
              state_next     = ST_CANDIDATE;
              cand_code_next = class_code;
              cand_dir_next  = step_up;
              valid_next     = 1'b0;
            end
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end
    end else if ((state != ST_IDLE) && timed_out) begin
      // The counter has stopped or slowed below the slowest rate; this is
      // not an error, just loss of signal. sw/ud keep their last lock.
      state_next = ST_IDLE;
      valid_next = 1'b0;
    end
  end

  // NOTE: the reset branch covers every flop in the block so nothing powers
  // up in an unknown state; there are no memories here that would be left
  // out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cand_code <= RATE_0HZ1;
      cand_dir  <= 1'b0;
      sw        <= RATE_0HZ1;
      ud        <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      cand_code <= cand_code_next;
      cand_dir  <= cand_dir_next;
      sw        <= sw_next;
      ud        <= ud_next;
      valid     <= valid_next;
      err       <= err_next;
    end
  end

endmodule

// File: tb/tb_led_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_led_rate_decoder
//   Directed bench for led_rate_decoder at CLK_HZ=1000 (20 ns clock), giving
//   periods P3=10, P2=100, P1=1000, P0=10000 cycles, tolerances 1/12/125/1250
//   and a timeout after 11250 cycles without a step.
//   Each step drives a new led value, queues the expected decoder response and
//   compares it five cycles later, once the strobe has been processed.
// -----------------------------------------------------------------------------
module tb_led_rate_decoder;
  import led_rate_pkg::*;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned TOL_SHIFT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led;
  logic [1:0] sw;
  logic       ud;
  logic       valid;
  logic       err;

  led_rate_decoder #(
    .CLK_HZ    (CLK_HZ),
    .TOL_SHIFT (TOL_SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .led   (led),
    .sw    (sw),
    .ud    (ud),
    .valid (valid),
    .err   (err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] sw;
    logic       ud;
    state_t     state;
    int         errs;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_fails    = 0;
  int   err_cycles = 0;

  // Counts every cycle err is high, so a stretched pulse shows up as > 1.
  always @(negedge clk) begin
    if (err === 1'b1) err_cycles++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one led value, hold it for gap cycles in total, and check the
  // decoder's response to that step.
  task automatic step(input logic [7:0] v, input int gap,
                      input logic ev, input logic [1:0] esw, input logic eud,
                      input state_t est, input int eerr);
    exp_t e;
    exp_t got;
    int   base;
    base    = err_cycles;
    led     = v;
    e.valid = ev;
    e.sw    = esw;
    e.ud    = eud;
    e.state = est;
    e.errs  = eerr;
    sb_q.push_back(e);
    wait_neg(5);
    if (sb_q.size() == 0) begin
      check($sformatf("step %02h scoreboard empty", v), 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("step %02h valid", v), 32'(valid), 32'(got.valid));
      check($sformatf("step %02h sw", v), 32'(sw), 32'(got.sw));
      check($sformatf("step %02h ud", v), 32'(ud), 32'(got.ud));
      check($sformatf("step %02h state", v), 32'(dut.state), 32'(got.state));
      check($sformatf("step %02h err cycles", v), 32'(err_cycles - base),
            32'(got.errs));
    end
    wait_neg(gap - 5);
  endtask

  initial begin
    int base;

    // ---------------- reset state ----------------
    reset = 1'b1;
    led   = 8'h00;
    wait_neg(3);
    check("reset valid", 32'(valid), 32'd0);
    check("reset sw", 32'(sw), 32'd0);
    check("reset ud", 32'(ud), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0;
    wait_neg(3);
    check("idle after reset", 32'(dut.state), 32'(ST_IDLE));

    // ---------------- 100 Hz up, intervals at the window edges 11 and 9 ----
    step(8'h01, 11,  1'b0, 2'd0, 1'b0, ST_MEASURE,   0);
    step(8'h02, 9,   1'b0, 2'd0, 1'b0, ST_CANDIDATE, 0);
    step(8'h03, 10,  1'b1, 2'd3, 1'b1, ST_LOCKED,    0);
    step(8'h04, 10,  1'b1, 2'd3, 1'b1, ST_LOCKED,    0);
    step(8'h05, 100, 1'b1, 2'd3, 1'b1, ST_LOCKED,    0);

    // ---------------- 10 Hz down through the 0x00 -> 0xFF wrap -------------
    step(8'h04, 100,  1'b0, 2'd3, 1'b1, ST_CANDIDATE, 0);
    step(8'h03, 100,  1'b1, 2'd2, 1'b0, ST_LOCKED,    0);
    step(8'h02, 100,  1'b1, 2'd2, 1'b0, ST_LOCKED,    0);
    step(8'h01, 100,  1'b1, 2'd2, 1'b0, ST_LOCKED,    0);
    step(8'h00, 100,  1'b1, 2'd2, 1'b0, ST_LOCKED,    0);
    step(8'hFF, 100,  1'b1, 2'd2, 1'b0, ST_LOCKED,    0);
    step(8'hFE, 1000, 1'b1, 2'd2, 1'b0, ST_LOCKED,    0);

    // ---------------- 1 Hz up (0xFF -> 0x00 wrap), then 0.1 Hz down -------
    step(8'hFF, 1000,  1'b0, 2'd2, 1'b0, ST_CANDIDATE, 0);
    step(8'h00, 1000,  1'b1, 2'd1, 1'b1, ST_LOCKED,    0);
    step(8'h01, 10000, 1'b1, 2'd1, 1'b1, ST_LOCKED,    0);
    step(8'h00, 10000, 1'b0, 2'd1, 1'b1, ST_CANDIDATE, 0);
    step(8'hFF, 10,    1'b1, 2'd0, 1'b0, ST_LOCKED,    0);

    // ---------------- illegal jumps while locked ---------------------------
    step(8'h0D, 10, 1'b0, 2'd0, 1'b0, ST_MEASURE,   1);
    step(8'h0E, 10, 1'b0, 2'd0, 1'b0, ST_CANDIDATE, 0);
    step(8'h0F, 10, 1'b1, 2'd3, 1'b1, ST_LOCKED,    0);
    step(8'h10, 10, 1'b1, 2'd3, 1'b1, ST_LOCKED,    0);
    step(8'h13, 10, 1'b0, 2'd3, 1'b1, ST_MEASURE,   1);

    // ---------------- timeout while locked ---------------------------------
    step(8'h14, 10, 1'b0, 2'd3, 1'b1, ST_CANDIDATE, 0);
    base = err_cycles;
    step(8'h15, 5,  1'b1, 2'd3, 1'b1, ST_LOCKED,    0);
    wait_neg(11225);
    check("freeze before limit valid", 32'(valid), 32'd1);
    check("freeze before limit state", 32'(dut.state), 32'(ST_LOCKED));
    wait_neg(40);
    check("timeout valid", 32'(valid), 32'd0);
    check("timeout state", 32'(dut.state), 32'(ST_IDLE));
    check("timeout sw held", 32'(sw), 32'd3);
    check("timeout ud held", 32'(ud), 32'd1);
    check("timeout no err", 32'(err_cycles - base), 32'd0);

    // ---------------- relock, then an interval of 8 at 100 Hz --------------
    step(8'h16, 10, 1'b0, 2'd3, 1'b1, ST_MEASURE,   0);
    step(8'h17, 10, 1'b0, 2'd3, 1'b1, ST_CANDIDATE, 0);
    step(8'h18, 8,  1'b1, 2'd3, 1'b1, ST_LOCKED,    0);
    step(8'h19, 10, 1'b0, 2'd3, 1'b1, ST_MEASURE,   1);

    // ---------------- reset while locked -----------------------------------
    step(8'h1A, 10, 1'b0, 2'd3, 1'b1, ST_CANDIDATE, 0);
    step(8'h1B, 7,  1'b1, 2'd3, 1'b1, ST_LOCKED,    0);
    #3;
    reset = 1'b1;
    led   = 8'h00;
    #1;
    check("mid reset valid", 32'(valid), 32'd0);
    check("mid reset sw", 32'(sw), 32'd0);
    check("mid reset ud", 32'(ud), 32'd0);
    check("mid reset err", 32'(err), 32'd0);
    check("mid reset state", 32'(dut.state), 32'(ST_IDLE));
    wait_neg(3);
    reset = 1'b0;
    wait_neg(2);
    step(8'h01, 10, 1'b0, 2'd0, 1'b0, ST_MEASURE,   0);
    step(8'h02, 10, 1'b0, 2'd0, 1'b0, ST_CANDIDATE, 0);
    step(8'h03, 10, 1'b1, 2'd3, 1'b1, ST_LOCKED,    0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
